fb_write_arbiter: RTL and testbench

- Shares the single framebuffer write port (fb_we/fb_addr/fb_wdata) between NUM_REQ screen painters and a built-in clear engine.
- Sits between the per-screen painters and the display framebuffer RAM.
- Painters stream pixels through a valid/ready handshake in bursts delimited by last.
- Grants are round-robin at burst boundaries; the clear engine fills the whole framebuffer with one colour on request.

---
 rtl/fb_write_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none

`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

// ============================================================================
// Module      : fb_write_arbiter
// Description : Shares the single framebuffer write port between NUM_REQ
//               screen painters (valid/ready bursts delimited by last) and a
//               built-in clear engine that fills the framebuffer with one
//               colour. Painters are granted round-robin at burst boundaries;
//               a requested clear runs between bursts, never inside one.
//               Optional build macro FB_ARB_TIMEOUT_EN adds an idle-owner
//               timeout that revokes a stalled grant and pulses arb_timeout.
//               ADDR_W defaults to `DISP_ADDR_WIDTH (17 if not defined).
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = `DISP_ADDR_WIDTH,
  parameter int FB_PIXELS = 76800
`ifdef FB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 255
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  input  logic [11:0]               clear_color,
  output logic                      clear_busy,
  output logic [2:0]                grant_id,
  output logic                      fb_we,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [31:0]               fb_wdata
`ifdef FB_ARB_TIMEOUT_EN
  ,
  output logic                      arb_timeout
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [2:0]        NO_GRANT   = 3'd7;
  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(FB_PIXELS - 1);

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [ADDR_W-1:0] r_clear_cnt;
  logic [11:0]       r_clear_color;
  logic              r_clear_pending;

  logic [ADDR_W-1:0] w_addr_arr  [NUM_REQ];
  logic [31:0]       w_wdata_arr [NUM_REQ];
  logic [IDX_W-1:0]  w_owner;
  logic [IDX_W-1:0]  w_owner_next;
  logic              w_xfer;
  logic              w_burst_done;
  logic              w_clear_done;
  logic              w_any_valid;
  logic [IDX_W-1:0]  w_pick;
  logic [IDX_W:0]    w_sum;
  logic              w_revoke;

  // Unpack the flat per-requester buses into indexable arrays.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = req_wdata[gi*32 +: 32];
  end

  // grant_id only carries a real index while in GRANT, so its low bits are the owner.
  assign w_owner      = grant_id[IDX_W-1:0];
  assign w_owner_next = (w_owner == IDX_W'(NUM_REQ - 1)) ? '0 : w_owner + 1'b1;
  assign w_xfer       = (r_state == ST_GRANT) && req_valid[w_owner];
  assign w_burst_done = w_xfer && req_last[w_owner];
  assign w_clear_done = (r_state == ST_CLEAR) && (r_clear_cnt == CLEAR_LAST);

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    w_any_valid = 1'b0;
    w_pick      = '0;
    w_sum       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_any_valid && req_valid[w_sum[IDX_W-1:0]]) begin
        w_any_valid = 1'b1;
        w_pick      = w_sum[IDX_W-1:0];
      end
    end
  end

  // Only the current owner sees ready, and only while it holds the grant.
  always_comb begin
    req_ready = '0;
    if (r_state == ST_GRANT) begin
      req_ready[w_owner] = 1'b1;
    end
  end

`ifdef FB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_idle_cnt;

  assign w_revoke = (r_state == ST_GRANT) && !req_valid[w_owner] &&
                    (r_idle_cnt == TO_W'(TIMEOUT - 1));

  // Count owner-idle cycles inside a grant; pulse arb_timeout on revocation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt  <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= w_revoke;
      if ((r_state != ST_GRANT) || w_xfer || w_revoke) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end
`else
  assign w_revoke = 1'b0;
`endif

  // Arbitration state machine: IDLE picks a clear or a painter, GRANT holds
  // the port until the owner's last beat, CLEAR sweeps the whole buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      grant_id    <= NO_GRANT;
      r_clear_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_clear_pending) begin
            r_state     <= ST_CLEAR;
            r_clear_cnt <= '0;
          end else if (w_any_valid) begin
            r_state  <= ST_GRANT;
            grant_id <= 3'(w_pick);
          end
        end
        ST_GRANT: begin
          if (w_burst_done || w_revoke) begin
            r_rr_ptr <= w_owner_next;
            grant_id <= NO_GRANT;
            r_state  <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (w_clear_done) begin
            r_clear_cnt <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_clear_cnt <= r_clear_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          grant_id <= NO_GRANT;
        end
      endcase
    end
  end

  // Clear request bookkeeping: a start while busy neither re-queues nor relatches colour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clear_pending <= 1'b0;
      clear_busy      <= 1'b0;
      r_clear_color   <= '0;
    end else begin
      if (clear_start && !clear_busy) begin
        r_clear_pending <= 1'b1;
        clear_busy      <= 1'b1;
        r_clear_color   <= clear_color;
      end
      if ((r_state == ST_IDLE) && r_clear_pending) begin
        r_clear_pending <= 1'b0;
      end
      if (w_clear_done) begin
        clear_busy <= 1'b0;
      end
    end
  end

  // Registered write port; address/data hold their last value when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else begin
      fb_we <= 1'b0;
      if (r_state == ST_CLEAR) begin
        fb_we    <= 1'b1;
        fb_addr  <= r_clear_cnt;
        fb_wdata <= {20'd0, r_clear_color};
      end else if (w_xfer) begin
        fb_we    <= 1'b1;
        fb_addr  <= w_addr_arr[w_owner];
        fb_wdata <= w_wdata_arr[w_owner];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none

// ============================================================================
// Module      : tb_fb_write_arbiter
// Description : Randomised and directed bench for fb_write_arbiter with a
//               cycle-level behavioural reference model and literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

  localparam int N   = 3;
  localparam int AW  = 17;
  localparam int PIX = 76800;
  localparam int CLR = -2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic            clear_start = 1'b0;
  logic [11:0]     clear_color = '0;
  logic            clear_busy;
  logic [2:0]      grant_id;
  logic            fb_we;
  logic [AW-1:0]   fb_addr;
  logic [31:0]     fb_wdata;
`ifdef FB_ARB_TIMEOUT_EN
  logic            arb_timeout;
`endif

  fb_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .FB_PIXELS(PIX)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .grant_id(grant_id), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata)
`ifdef FB_ARB_TIMEOUT_EN
    , .arb_timeout(arb_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_owner = -1;   // -1: nobody, CLR: clear sweep, else painter index
  int            m_ptr = 0;
  int            m_cidx = 0;
  bit            m_pend = 0;
  bit            m_busy = 0;
  logic [11:0]   m_color = '0;
  logic          e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0]   e_data = '0;
  logic [N-1:0]  m_xfer = '0;
  logic [N-1:0]  x_ready;
  logic [2:0]    x_gid;
  bit            busy_now;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_cidx = 0; m_pend = 0; m_busy = 0; m_color = '0;
      e_we = 1'b0; e_addr = '0; e_data = '0; m_xfer = '0;
      check("rst_fb_we", fb_we, 0);
      check("rst_grant_id", grant_id, 7);
      check("rst_req_ready", req_ready, 0);
      check("rst_clear_busy", clear_busy, 0);
    end else begin
      x_ready = '0;
      x_gid   = 3'd7;
      if (m_owner >= 0) begin
        x_ready[m_owner] = 1'b1;
        x_gid = 3'(m_owner);
      end
      check("req_ready", req_ready, x_ready);
      check("grant_id", grant_id, x_gid);
      check("clear_busy", clear_busy, m_busy);
      check("fb_we", fb_we, e_we);
      if (e_we) check("fb_addr_data", {fb_addr, fb_wdata}, {e_addr, e_data});

      busy_now = m_busy;
      e_we = 1'b0;
      m_xfer = '0;
      if (m_owner == CLR) begin
        e_we = 1'b1; e_addr = AW'(m_cidx); e_data = {20'd0, m_color};
        m_cidx++;
        if (m_cidx == PIX) begin m_owner = -1; m_busy = 0; end
      end else if (m_owner >= 0) begin
        if (req_valid[m_owner]) begin
          m_xfer[m_owner] = 1'b1;
          e_we = 1'b1;
          e_addr = req_addr[m_owner*AW +: AW];
          e_data = req_wdata[m_owner*32 +: 32];
          if (req_last[m_owner]) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
          end
        end
      end else if (m_pend) begin
        m_owner = CLR; m_cidx = 0; m_pend = 0;
      end else begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      if (clear_start && !busy_now) begin
        m_pend = 1; m_busy = 1; m_color = clear_color;
      end
    end
  end

  // ---------------- painter stimulus ----------------
  int p_left[N], p_bursts[N], p_len[N], p_beat[N], acc[N];
  bit gap_en = 0, rand_new = 0;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic painters_clear();
    for (int i = 0; i < N; i++) begin
      p_left[i] = 0; p_bursts[i] = 0; p_len[i] = 0; p_beat[i] = 0; acc[i] = 0;
    end
  endtask

  task automatic tick();
    cyc();
    clear_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_xfer[i] && p_left[i] > 0) begin p_left[i]--; p_beat[i]++; acc[i]++; end
      if (p_left[i] == 0 && p_bursts[i] > 0) begin
        p_bursts[i]--; p_left[i] = p_len[i]; p_beat[i] = 0;
      end
      if (rand_new && p_left[i] == 0 && $urandom_range(0, 7) == 0) begin
        p_left[i] = $urandom_range(1, 6); p_beat[i] = 0;
      end
      req_valid[i] = (p_left[i] > 0) && (!gap_en || $urandom_range(0, 3) != 0);
      req_last[i]  = (p_left[i] == 1);
      req_addr[i*AW +: AW]   = AW'($urandom);
      req_wdata[i*32 +: 32]  = {8'(i + 1), 8'(p_beat[i]), 16'($urandom)};
    end
    #2;
  endtask

  task automatic do_reset();
    cyc();
    reset_n = 1'b0;
    clear_start = 1'b0;
    req_valid = '0; req_last = '0;
    painters_clear();
    #1;
    check("reset_async_fb_we", fb_we, 0);
    check("reset_async_grant", grant_id, 7);
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  // Hard stop so a stuck design cannot hang the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  logic [2:0] gq[$];
  logic [2:0] prev_g;
  int n_we, n_rise, n_clr, n_pre, first_a, last_a;
  bit prev_we, sent, ign, saw_busy, done, seen;

  initial begin
    painters_clear();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_fb_we", fb_we, 0);
    check("reset_fb_addr", fb_addr, 0);
    check("reset_fb_wdata", fb_wdata, 0);
    check("reset_grant_id", grant_id, 7);
    check("reset_req_ready", req_ready, 0);
    check("reset_clear_busy", clear_busy, 0);
    reset_n = 1'b1;

    // Idle for 20 cycles.
    repeat (20) tick();
    check("idle_fb_we", fb_we, 0);
    check("idle_grant_id", grant_id, 7);
    check("idle_req_ready", req_ready, 0);

    // Single write from requester 0.
    cyc();
    req_valid = 3'b001; req_last = 3'b001;
    req_addr[0 +: AW] = 17'h00010; req_wdata[0 +: 32] = 32'h0000_0ABC;
    #2;
    check("single_ready_in_idle", req_ready, 3'b000);
    cyc(); #2;
    check("single_ready", req_ready, 3'b001);
    check("single_grant", grant_id, 0);
    cyc();
    req_valid = '0; req_last = '0;
    #2;
    check("single_fb_we", fb_we, 1);
    check("single_fb_addr", fb_addr, 17'h00010);
    check("single_fb_wdata", fb_wdata, 32'h0000_0ABC);
    check("single_grant_back", grant_id, 7);
    cyc(); #2;
    check("single_we_drop", fb_we, 0);

    // Round-robin with three requesters streaming 4-beat bursts.
    do_reset();
    for (int i = 0; i < N; i++) begin p_bursts[i] = 1; p_len[i] = 4; end
    p_bursts[0] = 2;
    prev_g = 3'd7; n_we = 0; n_rise = 0; prev_we = 0;
    repeat (60) begin
      tick();
      if (grant_id != 3'd7 && prev_g == 3'd7) gq.push_back(grant_id);
      prev_g = grant_id;
      if (fb_we) n_we++;
      if (fb_we && !prev_we) n_rise++;
      prev_we = fb_we;
    end
    check("rr_grant_count", gq.size(), 4);
    for (int k = 0; k < 4; k++)
      check("rr_grant_order", (k < gq.size()) ? gq[k] : 3'd7, (k == 1) ? 1 : (k == 2) ? 2 : 0);
    check("rr_write_count", n_we, 16);
    check("rr_write_runs", n_rise, 4);

    // Clear deferral: clear requested during beat 2 of a req1 burst.
    for (int i = 0; i < N; i++) acc[i] = 0;
    p_bursts[1] = 1; p_len[1] = 4;
    p_bursts[0] = 1; p_len[0] = 1;
    sent = 0; ign = 0; saw_busy = 0; done = 0;
    n_clr = 0; n_pre = 0; first_a = -1; last_a = -1;
    for (int c = 0; c < 80000 && !done; c++) begin
      tick();
      if (acc[1] == 1 && !sent) begin clear_start = 1'b1; clear_color = 12'hF00; sent = 1; end
      if (fb_we) begin
        if (fb_wdata == 32'h0000_0F00) begin
          if (n_clr == 0) first_a = int'(fb_addr);
          last_a = int'(fb_addr);
          n_clr++;
          if (fb_addr == AW'(PIX - 1)) check("clear_busy_fall", clear_busy, 0);
        end else if (n_clr == 0 && fb_wdata[31:24] == 8'd2) begin
          n_pre++;
        end
      end
      if (n_clr == 100 && !ign) begin clear_start = 1'b1; clear_color = 12'h0F0; ign = 1; end
      if (clear_busy) saw_busy = 1;
      if (saw_busy && !clear_busy) done = 1;
    end
    check("clear_done_in_budget", done, 1);
    check("clear_write_count", n_clr, PIX);
    check("clear_first_addr", first_a, 0);
    check("clear_last_addr", last_a, PIX - 1);
    check("clear_burst_beats_first", n_pre, 4);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (fb_we && fb_wdata[31:24] == 8'd1) seen = 1;
    end
    check("clear_resume_req0", seen, 1);
    check("clear_not_requeued", clear_busy, 0);

    // Reset in the middle of a clear.
    p_bursts[1] = 1; p_len[1] = 1;
    repeat (6) tick();
    clear_start = 1'b1; clear_color = 12'h00A;
    n_clr = 0;
    for (int c = 0; c < 2000 && n_clr < 1000; c++) begin
      tick();
      if (fb_we && fb_wdata == 32'h0000_000A) n_clr++;
    end
    check("midclear_reached", n_clr, 1000);
    do_reset();
    tick();
    check("midclear_busy_after", clear_busy, 0);
    p_bursts[1] = 1; p_len[1] = 1;
    p_bursts[2] = 1; p_len[2] = 1;
    prev_g = 3'd7; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (grant_id != 3'd7) begin prev_g = grant_id; seen = 1; end
    end
    check("midclear_next_grant", prev_g, 1);

    // Randomised traffic with gaps, varied burst lengths and wide addresses.
    repeat (20) tick();
    gap_en = 1; rand_new = 1;
    repeat (3000) tick();
    rand_new = 0;
    for (int c = 0; c < 500 && (p_left[0] + p_left[1] + p_left[2]) > 0; c++) tick();
    check("random_drained", p_left[0] + p_left[1] + p_left[2], 0);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
